easy_fifo_axis_pkt: RTL

Single-clock AXI-Stream FIFO with packet awareness. It is the next generation of the easy_fifo AXIS wrappers, generalised to arbitrary power-of-two depth. It adds a tlast-aware store-and-forward mode, packet counting, and almost-full/almost-empty flags. It sits between a packet producer and consumer in one clock domain, e.g. behind a CDC FIFO or in front of a framer.

---
 rtl/easy_fifo_axis_pkt_if.sv | 19 +
 rtl/easy_fifo_axis_pkt.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/easy_fifo_axis_pkt_if.sv
// AXI-Stream beat interface for easy_fifo_axis_pkt.
// master drives tdata/tvalid/tlast (and tuser with EASY_FIFO_PKT_DROP_EN); slave drives tready.
interface easy_fifo_axis_pkt_if #(
   parameter int unsigned DWIDTH = 32
) ();
   logic [DWIDTH-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;
`ifdef EASY_FIFO_PKT_DROP_EN
   logic              tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/easy_fifo_axis_pkt.sv
// Single-clock packet-aware AXI-Stream FIFO (store-and-forward or cut-through).
// Ports: clk, rst_n (async active-low); s_axis (slave, write side); m_axis (master,
//   read side); fifo_cnt (stored words); pkt_cnt (complete packets stored);
//   almost_full / almost_empty threshold flags.
// Optional macro EASY_FIFO_PKT_DROP_EN: adds s_axis.tuser error flag and drop_cnt;
//   errored or oversize packets are discarded instead of escaping to cut-through.
module easy_fifo_axis_pkt #(
   parameter int unsigned DWIDTH        = 32,
   parameter int unsigned DEPTH         = 64,
   parameter bit          PKT_MODE      = 1'b1,
   parameter int unsigned AFULL_THRESH  = DEPTH - 4,
   parameter int unsigned AEMPTY_THRESH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   easy_fifo_axis_pkt_if.slave       s_axis,
   easy_fifo_axis_pkt_if.master      m_axis,
   output logic [$clog2(DEPTH):0]    fifo_cnt,
   output logic [$clog2(DEPTH):0]    pkt_cnt,
   output logic                      almost_full,
   output logic                      almost_empty
`ifdef EASY_FIFO_PKT_DROP_EN
   ,
   output logic [15:0]               drop_cnt
`endif
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // {tlast, tdata} storage; contents need no reset
   logic [DWIDTH:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [PW-1:0] used, avail;
   logic          full, oversize, wr_fire, rd_fire, wr_store, out_last;

`ifdef EASY_FIFO_PKT_DROP_EN
   typedef enum logic {S_IDLE, S_DROP} state_e;
   state_e        state_q, state_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          drop_inc;
`else
   logic          esc_q, esc_d;
`endif

   assign used     = wr_ptr_q - rd_ptr_q;
   assign avail    = commit_ptr_q - rd_ptr_q;
   assign full     = (used == PW'(DEPTH));
   // Full of one unfinished packet: store-and-forward would deadlock
   assign oversize = PKT_MODE && full && (commit_ptr_q == rd_ptr_q);

`ifdef EASY_FIFO_PKT_DROP_EN
   assign s_axis.tready = rst_n & (~full | (state_q == S_DROP));
   assign m_axis.tuser  = 1'b0;
   assign drop_cnt      = drop_cnt_q;
`else
   assign s_axis.tready = rst_n & ~full;
`endif

   assign m_axis.tvalid = (avail != '0);
   assign {m_axis.tlast, m_axis.tdata} = m_axis.tvalid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

   assign wr_fire  = s_axis.tvalid & s_axis.tready;
   assign rd_fire  = m_axis.tvalid & m_axis.tready;
   assign out_last = rd_fire & m_axis.tlast;

   assign fifo_cnt     = used;
   assign pkt_cnt      = pkt_cnt_q;
   assign almost_full  = (used >= PW'(AFULL_THRESH));
   assign almost_empty = (used <= PW'(AEMPTY_THRESH));

   // Pointer, packet-count and write-mode next state
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      pkt_cnt_d    = pkt_cnt_q;
      wr_store     = 1'b0;
`ifdef EASY_FIFO_PKT_DROP_EN
      state_d      = state_q;
      drop_cnt_d   = drop_cnt_q;
      drop_inc     = 1'b0;
`else
      esc_d        = esc_q;
`endif

      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);

`ifdef EASY_FIFO_PKT_DROP_EN
      case (state_q)
         S_IDLE: begin
            if (oversize) begin
               // Roll back the unfinished packet and swallow its remainder
               wr_ptr_d = commit_ptr_q;
               state_d  = S_DROP;
            end else if (wr_fire && s_axis.tlast && s_axis.tuser) begin
               wr_ptr_d = commit_ptr_q;
               drop_inc = 1'b1;
            end else if (wr_fire) begin
               wr_store = 1'b1;
               wr_ptr_d = wr_ptr_q + PW'(1);
               if (s_axis.tlast || !PKT_MODE) commit_ptr_d = wr_ptr_q + PW'(1);
            end
         end
         default: begin
            if (wr_fire && s_axis.tlast) begin
               state_d  = S_IDLE;
               drop_inc = 1'b1;
            end
         end
      endcase
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
`else
      if (oversize) esc_d = 1'b1;
      if (wr_fire) begin
         wr_store = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (s_axis.tlast || !PKT_MODE) commit_ptr_d = wr_ptr_q + PW'(1);
         if (s_axis.tlast) esc_d = 1'b0;
      end
      // Escape: commit tracks the write pointer until the packet's tlast lands
      if (esc_q || oversize) commit_ptr_d = wr_ptr_d;
`endif

      if ((wr_store && s_axis.tlast) && !out_last)      pkt_cnt_d = pkt_cnt_q + PW'(1);
      else if (!(wr_store && s_axis.tlast) && out_last) pkt_cnt_d = pkt_cnt_q - PW'(1);
   end

   // Data array write
   always_ff @(posedge clk) begin
      if (wr_store) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pkt_cnt_q    <= '0;
`ifdef EASY_FIFO_PKT_DROP_EN
         state_q      <= S_IDLE;
         drop_cnt_q   <= '0;
`else
         esc_q        <= 1'b0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_cnt_q    <= pkt_cnt_d;
`ifdef EASY_FIFO_PKT_DROP_EN
         state_q      <= state_d;
         drop_cnt_q   <= drop_cnt_d;
`else
         esc_q        <= esc_d;
`endif
      end
   end
endmodule
